// File: rtl/mdu_pkg.sv
// Shared encodings and latency defaults for the multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    localparam int unsigned DEFAULT_MULT_CYCLES = 5;
    localparam int unsigned DEFAULT_DIV_CYCLES  = 10;

    // Ops 0-3 occupy the unit for several cycles; everything else is single-cycle or ignored.
    function automatic logic op_is_long(logic [2:0] op);
        return op[2] == 1'b0;
    endfunction

    function automatic logic op_is_div(md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Combinational signed/unsigned 32-bit divide; flags a zero divisor and returns zeros then.
module mdu_div_core
    import mdu_pkg::*;
(
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    logic        neg_n;
    logic        neg_d;
    logic [31:0] mag_n;
    logic [31:0] mag_d;
    logic [31:0] safe_d;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    // Divide magnitudes, then restore signs. 0x80000000 / -1 falls out as 0x80000000 rem 0
    // because the magnitude of 0x80000000 is itself and negating it wraps back.
    always_comb begin
        div_by_zero = (divisor == 32'd0);
        neg_n       = is_signed & dividend[31];
        neg_d       = is_signed & divisor[31];
        mag_n       = neg_n ? (32'd0 - dividend) : dividend;
        mag_d       = neg_d ? (32'd0 - divisor) : divisor;
        safe_d      = div_by_zero ? 32'd1 : mag_d;
        q_mag       = mag_n / safe_d;
        r_mag       = mag_n % safe_d;
        quotient    = (neg_n ^ neg_d) ? (32'd0 - q_mag) : q_mag;
        remainder   = neg_n ? (32'd0 - r_mag) : r_mag;
        if (div_by_zero) begin
            quotient  = 32'd0;
            remainder = 32'd0;
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// Fixed-latency multiply/divide unit owning HI/LO; busy covers the modelled latency.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    state_e           state_q;
    md_op_e           op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    logic        mul_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    // Extending both operands to 64 bits makes the low 64 bits of the product exact for
    // either signedness.
    always_comb begin
        mul_signed = op_is_signed(op_q);
        mul_a      = {{32{mul_signed & a_q[31]}}, a_q};
        mul_b      = {{32{mul_signed & b_q[31]}}, b_q};
        product    = mul_a * mul_b;
    end

    mdu_div_core u_div_core (
        .dividend    (a_q),
        .divisor     (b_q),
        .is_signed   (op_is_signed(op_q)),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= MD_MULT;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (op_is_long(md_op)) begin
                            op_q    <= md_op_e'(md_op);
                            a_q     <= A;
                            b_q     <= B;
                            cnt_q   <= op_is_div(md_op_e'(md_op)) ? CNT_W'(DIV_CYCLES)
                                                                  : CNT_W'(MULT_CYCLES);
                            busy_q  <= 1'b1;
                            state_q <= StRun;
                        end else if (md_op == MD_MTHI) begin
                            hi_q <= A;
                        end else if (md_op == MD_MTLO) begin
                            lo_q <= A;
                        end
                    end
                end
                StRun: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    // Counter hits zero on this edge: commit and release the hazard unit.
                    if (cnt_q == CNT_W'(1)) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                        if (!op_is_div(op_q)) begin
                            hi_q <= product[63:32];
                            lo_q <= product[31:0];
                        end else if (!div_by_zero) begin
                            hi_q <= remainder;
                            lo_q <= quotient;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed table, randomized ops vs. arithmetic model,
// and hand sequences for reset-in-flight and start-while-busy.
module tb_mdu_unit;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_tests;
    int n_fail;

    mdu_unit #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic int lat(input logic [2:0] op);
        if (op == 3'd0 || op == 3'd1) return MULT_N;
        if (op == 3'd2 || op == 3'd3) return DIV_N;
        return 0;
    endfunction

    // Reference semantics straight from the ISA rules, using wide integer arithmetic.
    task automatic model_exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              inout logic [31:0] hi, inout logic [31:0] lo);
        longint          sp;
        longint unsigned up;
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        case (op)
            3'd0: begin
                sa = $signed(a);
                sb = $signed(b);
                sp = sa * sb;
                hi = sp[63:32];
                lo = sp[31:0];
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                hi = up[63:32];
                lo = up[31:0];
            end
            3'd2: if (b != 32'd0) begin
                sa = $signed(a);
                sb = $signed(b);
                q  = sa / sb;
                r  = sa % sb;
                hi = r[31:0];
                lo = q[31:0];
            end
            3'd3: if (b != 32'd0) begin
                hi = a % b;
                lo = a / b;
            end
            3'd4: hi = a;
            3'd5: lo = a;
            default: ;
        endcase
    endtask

    // Called at #1 after an edge; returns at #1 after the issuing edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic count_busy(inout int n);
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int n;
        n = 0;
        issue(op, a, b);
        count_busy(n);
        check({name, "_busy_len"}, 32'(n), 32'(lat(op)));
        check({name, "_hi"}, HI, exp_hi);
        check({name, "_lo"}, LO, exp_lo);
    endtask

    initial begin
        logic [31:0] mhi;
        logic [31:0] mlo;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          n;

        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{3'd4, 32'h12345678, 32'd0,        32'h12345678, 32'h80000000};
        vecs[5]  = '{3'd3, 32'd7,        32'd0,        32'h12345678, 32'h80000000};
        vecs[6]  = '{3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[7]  = '{3'd5, 32'hCAFEF00D, 32'd0,        32'h00000002, 32'hCAFEF00D};
        vecs[8]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{3'd2, 32'd0,        32'd0,        32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{3'd6, 32'h00000001, 32'd3,        32'h00000001, 32'hFFFFFFFD};

        reset = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo);
        end
        mhi = vecs[10].exp_hi;
        mlo = vecs[10].exp_lo;

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 100));
                default: ;
            endcase
            model_exec(op, a, b, mhi, mlo);
            run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, mhi, mlo);
        end

        // MTLO during busy is dropped, and operand changes after issue have no effect.
        a = 32'h00012345;
        b = 32'hFFFFFFF9;
        model_exec(3'd0, a, b, mhi, mlo);
        n = 0;
        issue(3'd0, a, b);
        n = 1;
        @(posedge clk);
        #1;
        n = 2;
        start = 1'b1;
        md_op = 3'd5;
        A     = 32'hDEADBEEF;
        B     = 32'h00001234;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = 32'h55555555;
        count_busy(n);
        check("busy_start_len", 32'(n), 32'(MULT_N));
        check("busy_start_hi", HI, mhi);
        check("busy_start_lo", LO, mlo);

        // Reset in the middle of a run: everything clears and no late write follows.
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrun_reset_busy", {31'd0, busy}, 32'd0);
        check("midrun_reset_hi", HI, 32'd0);
        check("midrun_reset_lo", LO, 32'd0);
        repeat (DIV_N + 2) @(posedge clk);
        #1;
        check("midrun_late_busy", {31'd0, busy}, 32'd0);
        check("midrun_late_hi", HI, 32'd0);
        check("midrun_late_lo", LO, 32'd0);

        // Reset wins over a simultaneous start.
        reset = 1'b1;
        start = 1'b1;
        md_op = 3'd4;
        A     = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        check("reset_vs_start_busy", {31'd0, busy}, 32'd0);
        check("reset_vs_start_hi", HI, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the execute stage of the MIPS datapath, alongside the ALU.
- Consumes the same operand pair as the ALU: operand B is either the register value or the extended immediate from the extender.
- Owns the HI/LO registers; executes MULT/MULTU/DIV/DIVU with fixed latency and MTHI/MTLO in a single cycle.
- Reports busy so the hazard unit can stall MFHI/MFLO and subsequent MD instructions.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for MULT/MULTU (>=1)
- DIV_CYCLES, 10, cycles busy stays high for DIV/DIVU (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  issue strobe for the op on md_op, valid for one cycle
- md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
- A  input  32  operand A (rs value; source for MTHI/MTLO)
- B  input  32  operand B (rt value or extended immediate)
- busy  output  1  registered; high while a mult/div is in flight
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: busy=0, HI=0, LO=0, cycle counter=0. A pending result is discarded. Reset wins over start on the same edge.
- States: IDLE, RUN. Transitions happen only on the rising edge of clk.
- IDLE, start=1, op 0-3:
  - Latch A, B and op.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN; busy=1 from the next cycle.
- IDLE, start=1, op 4: HI<=A at that edge. Op 5: LO<=A at that edge. busy stays 0.
- IDLE, start=1, op 6-7: ignored, no state change.
- RUN:
  - Counter decrements each edge.
  - On the edge where the counter reaches 0, HI/LO are written and busy deasserts.
  - busy is high for exactly N cycles; HI/LO reflect the new result in the first cycle busy=0.
- start while busy=1: ignored entirely, including MTHI/MTLO. The hazard unit must stall; the unit does not queue.
- HI/LO keep their value throughout RUN. The result is computed from the latched operands, so changes on A/B after issue have no effect.
- MULT: signed 32x32->64 product; HI=[63:32], LO=[31:0].
- MULTU: unsigned 32x32->64 product; HI=[63:32], LO=[31:0].
- DIV (signed):
  - LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient to LO, remainder to HI.
- Divide by zero (B=0, DIV or DIVU): busy runs the full DIV_CYCLES; HI/LO are left unchanged.
- Result computation: a behavioural multiply/divide on the latched operands is acceptable. The counter models latency only; no iterative datapath is required.

Decomposition:
- Shared package:
  - md_op encodings (MD_MULT..MD_MTLO)
  - state encoding (IDLE, RUN)
  - default latency constants
- One natural sub-module: mdu_div_core, a combinational signed/unsigned divide with the zero-divisor and overflow rules, giving {quotient, remainder, div_by_zero}.
- The multiply stays inline.

Test Plan:
- Reset then idle → busy=0, HI=0, LO=0. Assert reset mid-RUN → next cycle busy=0, HI/LO=0, and no late write occurs.
- MULT A=0xFFFFFFFD (-3), B=5 → busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU A=0xFFFFFFFF, B=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 → busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Preload HI=0x12345678 via MTHI (next cycle HI updated, busy never rises), then DIVU A=7, B=0 → busy 10 cycles, HI still 0x12345678, LO unchanged.
- Issue MULT, then during busy pulse start with MTLO A=0xDEADBEEF and change A/B → LO ends as the product of the latched operands, not 0xDEADBEEF, and busy length is unchanged.
